decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction decode stage sitting between fetch and execute.
- Accepts a fetched instruction plus PC over a valid/ready handshake and emits decoded fields, a one-hot opcode class, a sign-extended XLEN immediate and an illegal-instruction flag.
- Generalises the combinational decoder:
  - XLEN parameter.
  - Full immediate coverage for all formats.
  - Illegal detection.
  - Pipeline register with stall and flush.
  - Optional skid buffer so that in_ready is a registered signal.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sizes the immediate and PC.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single pipeline register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries; same-cycle input is not accepted
- in_valid  in  1  instr/in_pc valid
- in_ready  out  1  stage can accept
- instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC of the decoded instruction
- rd_addr, rs1_addr, rs2_addr  out  5 each  instr[11:7], [19:15], [24:20]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- imm  out  XLEN  sign-extended immediate
- op_class  out  11  one-hot: r, i, load, s, b, jal, jalr, lui, auipc, fence, system (bit 0 = r)
- illegal  out  1  unrecognised encoding; op_class is 0 when set

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0; in_ready=1 in the following cycle.
  - All data outputs are 0.
  - Held entries are discarded.
  - rst overrides flush and any handshake.
- Transfer rules:
  - Input transfers when in_valid && in_ready && !flush.
  - Output transfers when out_valid && out_ready.
  - Latency is 1 cycle: an accepted instruction appears on out_* the next cycle.
- Throughput: one instruction per cycle when out_ready is held high.
- Output stability: while out_valid && !out_ready, every out_* field is stable.
- SKID=0:
  - One register.
  - in_ready = !out_valid || out_ready (combinational path).
- SKID=1:
  - States EMPTY, ONE, TWO.
  - in_ready = (state != TWO), registered.
  - EMPTY: accept -> ONE.
  - ONE:
    - accept without drain -> TWO;
    - drain without accept -> EMPTY;
    - accept and drain in the same cycle -> ONE.
  - TWO: drain -> ONE, and the skid entry moves to the output register.
  - Order is FIFO; no entry is lost or duplicated.
- Flush:
  - Next cycle out_valid=0 and state EMPTY.
  - Input presented in the flush cycle is dropped.
  - Flush in the same cycle as an output transfer: the transfer completes, then everything is emptied.
- Decode is performed before the register, so the registered outputs carry the decoded form.
- Immediates (sext = replicate instr[31] up to XLEN):
  - I, load, jalr: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U (lui, auipc): sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 copy instr[31].
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R, fence, system, illegal: imm = 0.
- Illegal conditions:
  - instr[1:0] != 2'b11; or
  - opcode not among the 11 classes; or
  - R-type with funct7 not 0000000 or 0100000.
- Illegal instructions still flow through with illegal=1; they are not dropped.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_S=0100011, OP_B=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111, OP_FENCE=0001111, OP_SYSTEM=1110011);
  - op_class bit indices;
  - decoded-bundle struct typedef, parameterised by XLEN via a localparam default.
- One natural sub-module: decode_comb, a pure combinational field/immediate/illegal decode. decode_stage wraps it with the handshake and skid logic.

Test Plan:
- XLEN=32, instr=0xFFF10093 (addi x1,x2,-1) -> next cycle out_valid=1, op_class=i, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0.
- instr=0x00512423 (sw x5,8(x2)) -> op_class=s, rs1=2, rs2=5, funct3=2, imm=0x00000008. Then instr=0xFE000EE3 (beq x0,x0,-4) -> op_class=b, imm=0xFFFFFFFC.
- XLEN=64: instr=0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000. Then instr=0x001000EF (jal x1,2048) -> imm=0x800, rd=1.
- SKID=1, stream of 4 instructions with out_ready low for 3 cycles -> in_ready falls after 2 accepts. On release, outputs appear in order, one per cycle, none lost or duplicated.
- Assert flush with two entries held and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears at the output.
- instr=0x00000013 with bits[1:0] forced to 00, and instr=0x0200_00B3 (R-type funct7=0000001) -> illegal=1, op_class=0, imm=0. Asserting rst mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, op_class bit
// positions and the decoded-field bundle passed from decode to execute.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int CLS_R      = 0;
    localparam int CLS_I      = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_S      = 3;
    localparam int CLS_B      = 4;
    localparam int CLS_JAL    = 5;
    localparam int CLS_JALR   = 6;
    localparam int CLS_LUI    = 7;
    localparam int CLS_AUIPC  = 8;
    localparam int CLS_FENCE  = 9;
    localparam int CLS_SYSTEM = 10;
    localparam int NUM_CLS    = 11;

    // XLEN-independent part of a decoded instruction; imm and pc
    // travel beside it at the width chosen by the instantiating stage.
    typedef struct packed {
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [NUM_CLS-1:0] op_class;
        logic               illegal;
    } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I/RV64I field, immediate and legality decode.
// Illegal encodings report op_class = 0 and imm = 0.
module decode_comb
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    logic [NUM_CLS-1:0] cls;
    logic [NUM_CLS-1:0] cls_ok;
    logic [31:0]        imm32;
    logic               r_bad;
    logic               bad;

    always_comb begin
        cls = '0;
        unique case (instr[6:0])
            OP_R:      cls[CLS_R]      = 1'b1;
            OP_I:      cls[CLS_I]      = 1'b1;
            OP_LOAD:   cls[CLS_LOAD]   = 1'b1;
            OP_S:      cls[CLS_S]      = 1'b1;
            OP_B:      cls[CLS_B]      = 1'b1;
            OP_JAL:    cls[CLS_JAL]    = 1'b1;
            OP_JALR:   cls[CLS_JALR]   = 1'b1;
            OP_LUI:    cls[CLS_LUI]    = 1'b1;
            OP_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
            OP_FENCE:  cls[CLS_FENCE]  = 1'b1;
            OP_SYSTEM: cls[CLS_SYSTEM] = 1'b1;
            default:   cls = '0;
        endcase

        r_bad = cls[CLS_R] &&
                (instr[31:25] != 7'b0000000) &&
                (instr[31:25] != 7'b0100000);
        bad = (instr[1:0] != 2'b11) || (cls == '0) || r_bad;
        cls_ok = bad ? '0 : cls;

        unique case (1'b1)
            cls_ok[CLS_I], cls_ok[CLS_LOAD], cls_ok[CLS_JALR]:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            cls_ok[CLS_S]:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            cls_ok[CLS_B]:
                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            cls_ok[CLS_LUI], cls_ok[CLS_AUIPC]:
                imm32 = {instr[31:12], 12'b0};
            cls_ok[CLS_JAL]:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    assign dec.rd       = instr[11:7];
    assign dec.rs1      = instr[19:15];
    assign dec.rs2      = instr[24:20];
    assign dec.funct3   = instr[14:12];
    assign dec.funct7   = instr[31:25];
    assign dec.op_class = cls_ok;
    assign dec.illegal  = bad;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute with valid/ready
// handshake, flush, and an optional two-entry skid buffer.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rd_addr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [10:0]     op_class,
    output logic            illegal
);

    typedef struct packed {
        dec_t            d;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    dec_t            dec_w;
    logic [XLEN-1:0] imm_w;
    entry_t          din;
    entry_t          head;
    logic            head_v;

    decode_comb #(.XLEN(XLEN)) u_dec (
        .instr (instr),
        .dec   (dec_w),
        .imm   (imm_w)
    );

    assign din = {dec_w, imm_w, in_pc};

    if (SKID == 0) begin : g_reg
        logic acc;

        assign in_ready = !head_v || out_ready;
        assign acc      = in_valid && in_ready && !flush;

        always_ff @(posedge clk) begin
            if (rst) begin
                head_v <= 1'b0;
                head   <= '0;
            end else if (flush) begin
                head_v <= 1'b0;
            end else if (acc) begin
                head_v <= 1'b1;
                head   <= din;
            end else if (out_ready) begin
                head_v <= 1'b0;
            end
        end
    end else begin : g_skid
        typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

        state_t state;
        state_t state_n;
        entry_t skid;
        logic   acc;
        logic   drain;
        logic   ld_head_in;
        logic   ld_head_skid;
        logic   ld_skid;

        // in_ready decodes the state register only: no path from out_ready
        assign in_ready = (state != TWO);
        assign head_v   = (state != EMPTY);
        assign acc      = in_valid && in_ready && !flush;
        assign drain    = head_v && out_ready;

        always_comb begin
            state_n      = state;
            ld_head_in   = 1'b0;
            ld_head_skid = 1'b0;
            ld_skid      = 1'b0;
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_n    = ONE;
                        ld_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && drain) begin
                        ld_head_in = 1'b1;
                    end else if (acc) begin
                        state_n = TWO;
                        ld_skid = 1'b1;
                    end else if (drain) begin
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_n      = ONE;
                        ld_head_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
            if (flush) begin
                state_n = EMPTY;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= EMPTY;
                head  <= '0;
                skid  <= '0;
            end else begin
                state <= state_n;
                if (ld_head_in) begin
                    head <= din;
                end else if (ld_head_skid) begin
                    head <= skid;
                end
                if (ld_skid) begin
                    skid <= din;
                end
            end
        end
    end

    assign out_valid = head_v;
    assign out_pc    = head.pc;
    assign rd_addr   = head.d.rd;
    assign rs1_addr  = head.d.rs1;
    assign rs2_addr  = head.d.rs2;
    assign funct3    = head.d.funct3;
    assign funct7    = head.d.funct7;
    assign imm       = head.imm;
    assign op_class  = head.d.op_class;
    assign illegal   = head.d.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table on three
// configurations plus skid, flush and reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        a_ir, a_ov, a_il;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [10:0] a_cls;

    logic        b_ir, b_ov, b_il;
    logic [31:0] b_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [10:0] b_cls;

    logic        c_ir, c_ov, c_il;
    logic [63:0] c_pc, c_imm;
    logic [4:0]  c_rd, c_rs1, c_rs2;
    logic [2:0]  c_f3;
    logic [6:0]  c_f7;
    logic [10:0] c_cls;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .SKID(1)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_ir),
        .instr(instr), .in_pc(pc32),
        .out_valid(a_ov), .out_ready(out_ready),
        .out_pc(a_pc), .rd_addr(a_rd), .rs1_addr(a_rs1),
        .rs2_addr(a_rs2), .funct3(a_f3), .funct7(a_f7),
        .imm(a_imm), .op_class(a_cls), .illegal(a_il)
    );

    decode_stage #(.XLEN(32), .SKID(0)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_ir),
        .instr(instr), .in_pc(pc32),
        .out_valid(b_ov), .out_ready(out_ready),
        .out_pc(b_pc), .rd_addr(b_rd), .rs1_addr(b_rs1),
        .rs2_addr(b_rs2), .funct3(b_f3), .funct7(b_f7),
        .imm(b_imm), .op_class(b_cls), .illegal(b_il)
    );

    decode_stage #(.XLEN(64), .SKID(1)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(c_ir),
        .instr(instr), .in_pc(pc64),
        .out_valid(c_ov), .out_ready(out_ready),
        .out_pc(c_pc), .rd_addr(c_rd), .rs1_addr(c_rs1),
        .rs2_addr(c_rs2), .funct3(c_f3), .funct7(c_f7),
        .imm(c_imm), .op_class(c_cls), .illegal(c_il)
    );

    typedef struct {
        logic [31:0] instr;
        logic [10:0] cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [31:0] ins,
                         input logic [31:0] p);
        instr = ins;
        pc32  = p;
        pc64  = {32'h8000_0000, p};
    endtask

    localparam logic [31:0] ADDI = 32'hFFF10093;

    initial begin
        tv[0]  = '{32'hFFF10093, 11'h002, 5'd1, 5'd2, 5'd31,
                   3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tv[1]  = '{32'h00512423, 11'h008, 5'd8, 5'd2, 5'd5,
                   3'd2, 7'h00, 64'h8, 1'b0};
        tv[2]  = '{32'hFE000EE3, 11'h010, 5'd29, 5'd0, 5'd0,
                   3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tv[3]  = '{32'h800000B7, 11'h080, 5'd1, 5'd0, 5'd0,
                   3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tv[4]  = '{32'h001000EF, 11'h020, 5'd1, 5'd0, 5'd1,
                   3'd0, 7'h00, 64'h800, 1'b0};
        tv[5]  = '{32'h00000010, 11'h000, 5'd0, 5'd0, 5'd0,
                   3'd0, 7'h00, 64'h0, 1'b1};
        tv[6]  = '{32'h020000B3, 11'h000, 5'd1, 5'd0, 5'd0,
                   3'd0, 7'h01, 64'h0, 1'b1};
        tv[7]  = '{32'h002081B3, 11'h001, 5'd3, 5'd1, 5'd2,
                   3'd0, 7'h00, 64'h0, 1'b0};
        tv[8]  = '{32'h402081B3, 11'h001, 5'd3, 5'd1, 5'd2,
                   3'd0, 7'h20, 64'h0, 1'b0};
        tv[9]  = '{32'hFFC08067, 11'h040, 5'd0, 5'd1, 5'd28,
                   3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tv[10] = '{32'h01032283, 11'h004, 5'd5, 5'd6, 5'd16,
                   3'd2, 7'h00, 64'h10, 1'b0};
        tv[11] = '{32'h12345117, 11'h100, 5'd2, 5'd8, 5'd3,
                   3'd5, 7'h09, 64'h1234_5000, 1'b0};
        tv[12] = '{32'h0FF0000F, 11'h200, 5'd0, 5'd0, 5'd31,
                   3'd0, 7'h07, 64'h0, 1'b0};
        tv[13] = '{32'h00000073, 11'h400, 5'd0, 5'd0, 5'd0,
                   3'd0, 7'h00, 64'h0, 1'b0};
        tv[14] = '{32'hFE512C23, 11'h008, 5'd24, 5'd2, 5'd5,
                   3'd2, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};

        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(ADDI, 32'h0000_0F00);
        do_reset();

        // reset state: input was valid during reset but must be ignored
        in_valid = 1'b0;
        chk("rst_ov_a", 64'(a_ov), 64'd0);
        chk("rst_ir_a", 64'(a_ir), 64'd1);
        chk("rst_ov_b", 64'(b_ov), 64'd0);
        chk("rst_ov_c", 64'(c_ov), 64'd0);
        chk("rst_pc_a", 64'(a_pc), 64'd0);
        chk("rst_imm_c", c_imm, 64'd0);
        chk("rst_cls_a", 64'(a_cls), 64'd0);

        // back-to-back table: one result per cycle, 1-cycle latency
        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].instr, 32'h1000 + 32'(4 * i));
            step();
            chk("ov_a", 64'(a_ov), 64'd1);
            chk("pc_a", 64'(a_pc), 64'(32'h1000 + 32'(4 * i)));
            chk("cls_a", 64'(a_cls), 64'(tv[i].cls));
            chk("rd_a", 64'(a_rd), 64'(tv[i].rd));
            chk("rs1_a", 64'(a_rs1), 64'(tv[i].rs1));
            chk("rs2_a", 64'(a_rs2), 64'(tv[i].rs2));
            chk("f3_a", 64'(a_f3), 64'(tv[i].f3));
            chk("f7_a", 64'(a_f7), 64'(tv[i].f7));
            chk("imm_a", 64'(a_imm), 64'(tv[i].imm[31:0]));
            chk("ill_a", 64'(a_il), 64'(tv[i].ill));
            chk("ov_b", 64'(b_ov), 64'd1);
            chk("imm_b", 64'(b_imm), 64'(tv[i].imm[31:0]));
            chk("cls_b", 64'(b_cls), 64'(tv[i].cls));
            chk("imm_c", c_imm, tv[i].imm);
            chk("cls_c", 64'(c_cls), 64'(tv[i].cls));
            chk("ill_c", 64'(c_il), 64'(tv[i].ill));
            chk("pc_c", c_pc,
                {32'h8000_0000, 32'h1000 + 32'(4 * i)});
        end
        in_valid = 1'b0;
        step();
        chk("drain_ov_a", 64'(a_ov), 64'd0);
        chk("drain_ov_b", 64'(b_ov), 64'd0);

        // skid: A,B fill both entries while execute stalls 3 cycles
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(ADDI, 32'h100);
        step();
        chk("sk1_ov", 64'(a_ov), 64'd1);
        chk("sk1_pc", 64'(a_pc), 64'h100);
        chk("sk1_ir", 64'(a_ir), 64'd1);
        chk("sk1_ir_b", 64'(b_ir), 64'd0);
        drive(ADDI, 32'h104);
        step();
        chk("sk2_pc", 64'(a_pc), 64'h100);
        chk("sk2_ir", 64'(a_ir), 64'd0);
        chk("sk2_pc_b", 64'(b_pc), 64'h100);
        drive(ADDI, 32'h108);
        step();
        chk("sk3_ov", 64'(a_ov), 64'd1);
        chk("sk3_pc", 64'(a_pc), 64'h100);
        chk("sk3_ir", 64'(a_ir), 64'd0);
        out_ready = 1'b1;
        step();
        chk("sk4_pc", 64'(a_pc), 64'h104);
        chk("sk4_ir", 64'(a_ir), 64'd1);
        step();
        chk("sk5_pc", 64'(a_pc), 64'h108);
        chk("sk5_ov", 64'(a_ov), 64'd1);
        drive(ADDI, 32'h10C);
        step();
        chk("sk6_pc", 64'(a_pc), 64'h10C);
        in_valid = 1'b0;
        step();
        chk("sk7_ov", 64'(a_ov), 64'd0);

        // flush with two entries held and a new input offered
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(ADDI, 32'h200);
        step();
        drive(ADDI, 32'h204);
        step();
        chk("fl_pre_ir", 64'(a_ir), 64'd0);
        drive(ADDI, 32'h208);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_ov_a", 64'(a_ov), 64'd0);
        chk("fl_ir_a", 64'(a_ir), 64'd1);
        chk("fl_ov_b", 64'(b_ov), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_quiet", 64'(a_ov), 64'd0);
        end

        // flush while the head is transferring: all empty next cycle
        in_valid = 1'b1;
        drive(ADDI, 32'h300);
        step();
        chk("flx_ov_pre", 64'(a_ov), 64'd1);
        drive(ADDI, 32'h304);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flx_ov", 64'(a_ov), 64'd0);
        chk("flx_ov_c", 64'(c_ov), 64'd0);

        // reset mid-stream
        in_valid = 1'b1;
        drive(tv[2].instr, 32'h400);
        step();
        chk("rm_pre_ov", 64'(a_ov), 64'd1);
        drive(tv[3].instr, 32'h404);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rm_ov_a", 64'(a_ov), 64'd0);
        chk("rm_ov_b", 64'(b_ov), 64'd0);
        chk("rm_ir_a", 64'(a_ir), 64'd1);
        chk("rm_imm_c", c_imm, 64'd0);
        chk("rm_pc_a", 64'(a_pc), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
